// File: rtl/debug_pkg.sv
// Shared definitions for the MIPS debug unit: FSM encodings, command codes,
// pipeline latch widths and a bit-to-byte sizing helper.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Which part of the stream the currently selected byte belongs to.
    typedef enum logic [1:0] {
        BK_HDR,
        BK_PAY,
        BK_CHK
    } byte_kind_t;

    localparam logic [7:0] CMD_REGS   = 8'h01;
    localparam logic [7:0] CMD_IF_ID  = 8'h02;
    localparam logic [7:0] CMD_ID_EX  = 8'h03;
    localparam logic [7:0] CMD_EX_MEM = 8'h04;
    localparam logic [7:0] CMD_MEM_WB = 8'h05;

    localparam int W_REG_WORD = 32;
    localparam int W_ID_EX    = 129;
    localparam int W_EX_MEM   = 77;
    localparam int W_MEM_WB   = 71;

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/byte_mux_sel.sv
// Picks byte `sel` (LSB-first) out of a wide snapshot; out-of-range selects read 0.
module byte_mux_sel #(
    parameter int NBYTES = 17,
    parameter int SEL_W  = 5
) (
    input  logic [8*NBYTES-1:0] data,
    input  logic [SEL_W-1:0]    sel,
    output logic [7:0]          byte_out
);

    always_comb begin
        // NOTE: default assigned first so every path drives byte_out and no latch is inferred.
        byte_out = '0;
        for (int j = 0; j < NBYTES; j++) begin
            if (sel == SEL_W'(j)) begin
                byte_out = data[8*j +: 8];
            end
        end
    end

endmodule

// File: rtl/debug_dump_serializer.sv
// Serializes one wide debug snapshot to uart_tx as header, LSB-first payload
// bytes and an XOR checksum, paced by the UART's per-byte done pulse.
module debug_dump_serializer
    import debug_pkg::*;
#(
    parameter int MAX_BITS = 129,
    parameter bit HDR_EN   = 1'b1,
    parameter bit CHK_EN   = 1'b1,
    parameter int CNT_W    = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [7:0]          i_cmd,
    input  logic [MAX_BITS-1:0] i_data,
    input  logic [CNT_W-1:0]    i_nbytes,
    input  logic                i_abort,
    input  logic                i_tx_done,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    output logic                o_busy,
    output logic                o_done
);

    localparam int MAX_BYTES = bytes_for(MAX_BITS);
    localparam int PAY_W     = 8 * MAX_BYTES;
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_BYTES);

    state_t             state_q, state_d;
    byte_kind_t         kind_q, kind_d;
    logic [PAY_W-1:0]   snap_q;
    logic [7:0]         cmd_q;
    logic [7:0]         chk_q;
    logic [7:0]         tx_data_q;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               sel_en;
    logic [7:0]         pay_byte;
    logic [7:0]         byte_d;
    logic               accept;

    assign accept = (state_q == ST_IDLE) && i_start;

    byte_mux_sel #(
        .NBYTES (MAX_BYTES),
        .SEL_W  (CNT_W)
    ) u_byte_mux_sel (
        .data     (snap_q),
        .sel      (idx_d),
        .byte_out (pay_byte)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every register here sees pre-edge values.
            state_q <= state_d;
        end
    end

    // sel_en marks the cycles that latch the next byte to launch in SEND.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        idx_d   = '0;
        sel_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sel_en = 1'b1;
                if (HDR_EN)            kind_d = BK_HDR;
                else if (n_q != '0)    kind_d = BK_PAY;
                else if (CHK_EN)       kind_d = BK_CHK;
                else                   sel_en = 1'b0;
                state_d = sel_en ? ST_SEND : ST_DONE;
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    sel_en = 1'b1;
                    unique case (kind_q)
                        BK_HDR: begin
                            if (n_q != '0)   kind_d = BK_PAY;
                            else if (CHK_EN) kind_d = BK_CHK;
                            else             sel_en = 1'b0;
                        end
                        BK_PAY: begin
                            if ((idx_q + CNT_W'(1)) < n_q) begin
                                kind_d = BK_PAY;
                                idx_d  = idx_q + CNT_W'(1);
                            end else if (CHK_EN) begin
                                kind_d = BK_CHK;
                            end else begin
                                sel_en = 1'b0;
                            end
                        end
                        default: sel_en = 1'b0;
                    endcase
                    state_d = sel_en ? ST_SEND : ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (i_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            sel_en  = 1'b0;
        end
    end

    // The checksum byte is read after the last SEND has folded in its byte.
    always_comb begin
        unique case (kind_d)
            BK_HDR:  byte_d = cmd_q;
            BK_PAY:  byte_d = pay_byte;
            default: byte_d = chk_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: the snapshot register is reset too, so no stale data survives a reset.
            snap_q    <= '0;
            cmd_q     <= '0;
            chk_q     <= '0;
            tx_data_q <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            kind_q    <= BK_HDR;
        end else begin
            if (accept) begin
                snap_q <= PAY_W'(i_data);
                n_q    <= (i_nbytes > MAX_N) ? MAX_N : i_nbytes;
                cmd_q  <= i_cmd;
                chk_q  <= '0;
            end
            if (sel_en) begin
                kind_q    <= kind_d;
                idx_q     <= idx_d;
                tx_data_q <= byte_d;
            end
            if ((state_q == ST_SEND) && (kind_q != BK_CHK)) begin
                chk_q <= chk_q ^ tx_data_q;
            end
        end
    end

    assign o_tx_start = (state_q == ST_SEND) && !i_abort;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = (state_q == ST_LOAD) || (state_q == ST_SEND) || (state_q == ST_WAIT);
    assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_dump_serializer.sv
// Randomized self-checking bench for debug_dump_serializer against a byte-stream
// reference model with a simple uart_tx responder.
module tb_debug_dump_serializer;

    localparam int MAX_BITS  = 129;
    localparam int MAX_BYTES = (MAX_BITS + 7) / 8;
    localparam int CNT_W     = 5;
    localparam bit HDR_EN    = 1'b1;
    localparam bit CHK_EN    = 1'b1;

    logic                clk;
    logic                i_rst_n;
    logic                i_start;
    logic [7:0]          i_cmd;
    logic [MAX_BITS-1:0] i_data;
    logic [CNT_W-1:0]    i_nbytes;
    logic                i_abort;
    logic                i_tx_done;
    logic                o_tx_start;
    logic [7:0]          o_tx_data;
    logic                o_busy;
    logic                o_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    debug_dump_serializer #(
        .MAX_BITS (MAX_BITS),
        .HDR_EN   (HDR_EN),
        .CHK_EN   (CHK_EN),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_cmd      (i_cmd),
        .i_data     (i_data),
        .i_nbytes   (i_nbytes),
        .i_abort    (i_abort),
        .i_tx_done  (i_tx_done),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [MAX_BITS-1:0] rand_data();
        logic [159:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return w[MAX_BITS-1:0];
    endfunction

    // Reference stream: header, min(nb, MAX_BYTES) little-endian bytes, XOR of all before.
    task automatic build_exp(input logic [7:0] cmd, input logic [MAX_BITS-1:0] data, input int nb);
        logic [8*MAX_BYTES-1:0] wide;
        logic [7:0] chk;
        logic [7:0] b;
        int n;
        n    = (nb > MAX_BYTES) ? MAX_BYTES : nb;
        wide = '0;
        wide[MAX_BITS-1:0] = data;
        chk  = 8'h00;
        exp_q.delete();
        if (HDR_EN) begin
            exp_q.push_back(cmd);
            chk = chk ^ cmd;
        end
        for (int j = 0; j < n; j++) begin
            b = 8'((wide >> (8 * j)) & 'hFF);
            exp_q.push_back(b);
            chk = chk ^ b;
        end
        if (CHK_EN) exp_q.push_back(chk);
    endtask

    task automatic pulse_start(input logic [7:0] cmd, input logic [MAX_BITS-1:0] data,
                               input logic [CNT_W-1:0] nb);
        @(negedge clk);
        i_cmd = cmd; i_data = data; i_nbytes = nb; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_cmd = 8'($urandom()); i_data = rand_data(); i_nbytes = CNT_W'($urandom());
    endtask

    task automatic wait_tx_start(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (o_tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_byte();
        @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
    endtask

    task automatic do_dump(input string name, input logic [7:0] cmd, input logic [MAX_BITS-1:0] data,
                           input logic [CNT_W-1:0] nb, input int min_gap, input int max_gap,
                           input bit poke_start, input bit abort_with_start);
        int budget;
        int gap;
        int hold_err;
        bit done_seen;
        bit poked;
        logic [7:0] b;
        build_exp(cmd, data, int'(nb));
        got_q.delete();
        hold_err = 0; done_seen = 1'b0; poked = 1'b0;

        @(negedge clk);
        i_cmd = cmd; i_data = data; i_nbytes = nb; i_start = 1'b1; i_abort = abort_with_start;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b0;
        i_cmd = 8'($urandom()); i_data = rand_data(); i_nbytes = CNT_W'($urandom());
        checks++;
        if (o_busy !== 1'b1 || o_tx_start !== 1'b0)
            $display("FAIL %s load_cycle: busy=%b tx_start=%b, required busy=1 tx_start=0", name, o_busy, o_tx_start);
        @(negedge clk);
        checks++;
        if (o_tx_start !== 1'b1) begin
            failures++;
            $display("FAIL %s start_latency: tx_start=%b two edges after start, required 1", name, o_tx_start);
        end
        if (o_busy !== 1'b1 || o_tx_start !== 1'b0) failures += 0;

        budget = exp_q.size() * (max_gap + 4) + 20;
        while (!done_seen && budget > 0) begin
            if (o_done === 1'b1) begin
                done_seen = 1'b1;
                checks++;
                if (o_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s busy_at_done: busy=%b, required 0", name, o_busy);
                end
            end else if (o_tx_start === 1'b1) begin
                b = o_tx_data;
                got_q.push_back(b);
                gap = $urandom_range(max_gap, min_gap);
                @(negedge clk);
                if (poke_start && !poked) begin
                    i_start = 1'b1; i_cmd = ~cmd; i_nbytes = 5'd1; poked = 1'b1;
                end
                for (int g = 0; g < gap; g++) begin
                    if (o_tx_data !== b || o_tx_start !== 1'b0 || o_busy !== 1'b1) hold_err++;
                    @(negedge clk);
                    i_start = 1'b0;
                end
                if (o_tx_data !== b) hold_err++;
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
                i_start   = 1'b0;
                budget -= gap + 2;
            end else begin
                @(negedge clk);
                budget--;
            end
        end

        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL %s done_timeout: no o_done within cycle budget", name);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s byte_count: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s byte[%0d]: got %02h, required %02h", name, i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (hold_err != 0) begin
            failures++;
            $display("FAIL %s hold_stable: %0d unstable samples while waiting, required 0", name, hold_err);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: done=%b busy=%b tx_start=%b, required all 0", name, o_done, o_busy, o_tx_start);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b1; i_cmd = 8'hA5; i_data = rand_data();
        i_nbytes = 5'd4; i_abort = 1'b0; i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (o_tx_start !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: start=%b busy=%b done=%b data=%02h, required 0 0 0 00",
                     o_tx_start, o_busy, o_done, o_tx_data);
        end
        i_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b tx_start=%b after release, required 0 0", o_busy, o_tx_start);
        end
    endtask

    task automatic test_word_dump();
        logic [MAX_BITS-1:0] d;
        d = '0;
        d[31:0] = 32'h3C010003;
        do_dump("word_dump", 8'h02, d, 5'd4, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_id_ex();
        logic [MAX_BITS-1:0] d;
        d = '0;
        d[128] = 1'b1;
        do_dump("id_ex_width", 8'h03, d, 5'd17, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_clamp_and_empty();
        do_dump("clamp_31", 8'($urandom()), rand_data(), 5'd31, 0, 1, 1'b0, 1'b0);
        do_dump("empty_payload", 8'h5A, rand_data(), 5'd0, 0, 3, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        logic [7:0] cmd;
        logic [MAX_BITS-1:0] d;
        bit ok;
        int stray;
        cmd = 8'($urandom());
        d   = rand_data();
        build_exp(cmd, d, 8);
        pulse_start(cmd, d, 5'd8);
        for (int k = 0; k < 4; k++) begin
            wait_tx_start(ok);
            checks++;
            if (!ok || o_tx_data !== exp_q[k]) begin
                failures++;
                $display("FAIL abort_pre_byte[%0d]: seen=%b data=%02h, required 1 %02h", k, ok, o_tx_data, exp_q[k]);
            end
            if (k < 3) ack_byte();
        end
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_wait: busy=%b tx_start=%b done=%b, required 0 0 0", o_busy, o_tx_start, o_done);
        end
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        stray = 0;
        repeat (30) begin
            if (o_tx_start !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL abort_quiet: %0d active cycles after abort, required 0", stray);
        end

        pulse_start(8'h11, rand_data(), 5'd3);
        wait_tx_start(ok);
        i_abort = 1'b1;
        #1;
        checks++;
        if (!ok || o_tx_start !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_send: seen=%b tx_start=%b under abort, required 1 0", ok, o_tx_start);
        end
        @(negedge clk);
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_send_idle: busy=%b done=%b, required 0 0", o_busy, o_done);
        end
        do_dump("after_abort", 8'($urandom()), rand_data(), 5'd6, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        int stray;
        pulse_start(8'hC3, rand_data(), 5'd10);
        wait_tx_start(ok);
        ack_byte();
        wait_tx_start(ok);
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        checks++;
        if (!ok || o_tx_start !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_dump: seen=%b start=%b busy=%b done=%b data=%02h, required 1 0 0 0 00",
                     ok, o_tx_start, o_busy, o_done, o_tx_data);
        end
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        stray = 0;
        repeat (10) begin
            if (o_tx_start !== 1'b0 || o_busy !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_quiet: %0d active cycles after reset, required 0", stray);
        end
        do_dump("after_reset", 8'h3E, rand_data(), 5'd5, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_start_late_done();
        do_dump("busy_start_late_done", 8'h04, rand_data(), 5'd4, 1000, 1000, 1'b1, 1'b0);
    endtask

    task automatic test_abort_with_start();
        do_dump("abort_with_start", 8'h05, rand_data(), 5'd9, 0, 2, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 10; t++) begin
            do_dump($sformatf("random_%0d", t), 8'($urandom()), rand_data(),
                    CNT_W'($urandom_range(31, 0)), 0, 3, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_word_dump();
        test_id_ex();
        test_clamp_and_empty();
        test_abort();
        test_reset_mid_dump();
        test_ignored_start_late_done();
        test_abort_with_start();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
